// File: rtl/param_readback_tx_if.sv
// param_readback_tx_if: readback request/parameter/serial bundle (master drives req+params, slave drives tx/busy/done)
interface param_readback_tx_if;
  logic req;
  logic [23:0] per;
  logic [15:0] p1wid;
  logic [15:0] del;
  logic [15:0] p2wid;
  logic cp;
  logic bl;
  logic tx;
  logic busy;
  logic done;
  modport master (output req, per, p1wid, del, p2wid, cp, bl, input tx, busy, done);
  modport slave (input req, per, p1wid, del, p2wid, cp, bl, output tx, busy, done);
endinterface

// File: rtl/param_readback_tx.sv
// param_readback_tx: UART 8N1 readback of pulse parameters; clk, async reset, bus.slave (req/params in, tx/busy/done out); READBACK_CHECKSUM_EN appends an XOR byte
module param_readback_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input logic clk,
  input logic reset,
  param_readback_tx_if.slave bus
);
`ifdef READBACK_CHECKSUM_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif
  localparam logic [3:0] LAST = 4'(NB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;
  state_t state;
  logic [8*NB-1:0] pkt;
  logic [8*NB-1:0] snap;
  logic [87:0] base;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [3:0] byte_idx;
  logic [3:0] nxt;
  logic [7:0] shift;
  logic pending;
  logic wrap;
  assign base = {6'b0, bus.bl, bus.cp, bus.p2wid[7:0], bus.p2wid[15:8], bus.del[7:0], bus.del[15:8],
                 bus.p1wid[7:0], bus.p1wid[15:8], bus.per[7:0], bus.per[15:8], bus.per[23:16], HEADER};
`ifdef READBACK_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 1; i < 11; i++) csum ^= base[8*i +: 8];
  end
  assign pkt = {csum, base};
`else
  assign pkt = base;
`endif
  assign wrap = cnt == 16'(CLKS_PER_BIT - 1);
  assign nxt = byte_idx + 4'd1;
  // The inter-byte decision is taken on the final stop-bit edge, so NEXT is never occupied.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.tx <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      pending <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      shift <= '0;
      snap <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE) cnt <= wrap ? 16'd0 : cnt + 16'd1;
      if (state != IDLE && bus.req) pending <= 1'b1;
      case (state)
        IDLE: if (bus.req || pending) begin
          snap <= pkt;
          shift <= pkt[7:0];
          byte_idx <= '0;
          bus.tx <= 1'b0;
          bus.busy <= 1'b1;
          pending <= 1'b0;
          state <= START;
        end
        START: if (wrap) begin
          bus.tx <= shift[0];
          shift <= shift >> 1;
          bit_idx <= '0;
          state <= DATA;
        end
        DATA: if (wrap) begin
          if (bit_idx == 3'd7) begin
            bus.tx <= 1'b1;
            state <= STOP;
          end else begin
            bus.tx <= shift[0];
            shift <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: if (wrap) begin
          if (byte_idx < LAST) begin
            byte_idx <= nxt;
            shift <= snap[{nxt, 3'b000} +: 8];
            bus.tx <= 1'b0;
            state <= START;
          end else begin
            // A queued or coincident request keeps busy high; IDLE relaunches on the next edge.
            bus.done <= 1'b1;
            bus.busy <= pending | bus.req;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_param_readback_tx.sv
// tb_param_readback_tx: table-driven + scoreboard bench for param_readback_tx
module tb_param_readback_tx;
`ifdef READBACK_CHECKSUM_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif
  typedef struct {
    logic [23:0] per;
    logic [15:0] p1, dl, p2;
    logic cp, bl;
    logic [87:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int dcount = 0;
  logic [7:0] q[$];
  vec_t v[4];
  param_readback_tx_if b0();
  param_readback_tx_if b1();
  param_readback_tx #(.CLKS_PER_BIT(4)) u0 (.clk(clk), .reset(rst), .bus(b0));
  param_readback_tx #(.CLKS_PER_BIT(104)) u1 (.clk(clk), .reset(rst), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input vec_t x);
    b0.per = x.per; b0.p1wid = x.p1; b0.del = x.dl; b0.p2wid = x.p2; b0.cp = x.cp; b0.bl = x.bl;
  endtask

  task automatic push_vec(input vec_t x);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 11; k++) begin
      q.push_back(x.exp[87-8*k -: 8]);
      if (k > 0) c ^= x.exp[87-8*k -: 8];
    end
    if (NB == 12) q.push_back(c);
  endtask

  task automatic pulse_req();
    b0.req = 1'b1;
    @(negedge clk);
    b0.req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int i;
    i = 0;
    while (!b0.done && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(name, {31'd0, b0.done}, 32'd1);
  endtask

  // serial decoder for u0: start found at cycle s, data sampled at s+5+4k, stop at s+37
  initial begin
    logic act;
    int mc;
    logic [7:0] mb;
    act = 1'b0; mc = 0; mb = '0;
    forever begin
      @(negedge clk);
      if (rst) act = 1'b0;
      else if (!act) begin
        if (b0.tx == 1'b0) begin act = 1'b1; mc = 0; end
      end else begin
        mc++;
        if (mc >= 5 && mc <= 33 && (mc - 5) % 4 == 0) mb = {b0.tx, mb[7:1]};
        if (mc == 37) begin
          chk("stop bit", {31'd0, b0.tx}, 32'd1);
          if (q.size() == 0) chk("unexpected byte", {24'd0, mb}, 32'hFFFF_FFFF);
          else chk("byte", {24'd0, mb}, {24'd0, q.pop_front()});
          act = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (b0.done) dcount++;
  end

  logic e_on = 1'b0;
  logic seen = 1'b0;
  int t1 = 0;
  initial begin
    logic ptx;
    ptx = 1'b1;
    forever begin
      @(negedge clk);
      if (e_on && b1.tx !== ptx) begin
        if (!seen) begin seen = 1'b1; t1 = cyc; end
        else chk("bit edge alignment", (cyc - t1) % 104, 0);
      end
      ptx = b1.tx;
    end
  end

  initial begin
    int t0, d0, i;
    v[0] = '{24'h0186A0, 16'h0032, 16'h01F4, 16'h0064, 1'b1, 1'b0, 88'hA5_01_86_A0_00_32_01_F4_00_64_01};
    v[1] = '{24'hFFFFFF, 16'hFFFF, 16'h0000, 16'h8001, 1'b0, 1'b1, 88'hA5_FF_FF_FF_FF_FF_00_00_80_01_02};
    v[2] = '{24'h000000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 88'hA5_00_00_00_00_00_00_00_00_00_00};
    v[3] = '{24'h123456, 16'hABCD, 16'h5A5A, 16'h0F0F, 1'b1, 1'b1, 88'hA5_12_34_56_AB_CD_5A_5A_0F_0F_03};
    b0.req = 1'b0;
    set_in(v[0]);
    b1.req = 1'b0; b1.per = v[0].per; b1.p1wid = v[0].p1; b1.del = v[0].dl; b1.p2wid = v[0].p2;
    b1.cp = v[0].cp; b1.bl = v[0].bl;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle tx/busy/done", {29'd0, b0.tx, b0.busy, b0.done}, 32'b100);
    end
    // single packets, inputs scrambled mid-packet to exercise the snapshot
    for (int n = 0; n < 4; n++) begin
      set_in(v[n]);
      push_vec(v[n]);
      pulse_req();
      chk("busy after req", {31'd0, b0.busy}, 32'd1);
      chk("start bit after req", {31'd0, b0.tx}, 32'd0);
      t0 = cyc;
      repeat (100) @(negedge clk);
      b0.per = ~v[n].per; b0.p1wid = ~v[n].p1; b0.del = ~v[n].dl; b0.p2wid = ~v[n].p2;
      b0.cp = ~v[n].cp; b0.bl = ~v[n].bl;
      wait_done("done timeout", NB * 40 + 20);
      chk("packet latency", cyc - t0, NB * 40);
      chk("busy cleared at done", {31'd0, b0.busy}, 32'd0);
      repeat (10) @(negedge clk);
    end
    chk("queue drained", q.size(), 0);
    // pending: three reqs during packet A collapse into one packet B
    d0 = dcount;
    set_in(v[1]);
    push_vec(v[1]);
    pulse_req();
    t0 = cyc;
    repeat (50) @(negedge clk);
    set_in(v[3]);
    push_vec(v[3]);
    pulse_req();
    repeat (40) @(negedge clk);
    pulse_req();
    repeat (200) @(negedge clk);
    pulse_req();
    wait_done("pending done1 timeout", NB * 40);
    chk("pending done1 latency", cyc - t0, NB * 40);
    chk("busy held through done", {31'd0, b0.busy}, 32'd1);
    t0 = cyc;
    @(negedge clk);
    chk("back-to-back start bit", {31'd0, b0.tx}, 32'd0);
    chk("back-to-back busy", {31'd0, b0.busy}, 32'd1);
    @(negedge clk);
    wait_done("pending done2 timeout", NB * 40 + 5);
    chk("pending done2 latency", cyc - t0, NB * 40 + 1);
    chk("busy after second packet", {31'd0, b0.busy}, 32'd0);
    repeat (NB * 40 + 50) @(negedge clk);
    chk("exactly two dones", dcount - d0, 2);
    chk("queue drained after pending", q.size(), 0);
    // reset mid byte 5 aborts the packet
    d0 = dcount;
    set_in(v[0]);
    push_vec(v[0]);
    pulse_req();
    repeat (220) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("tx high on reset", {31'd0, b0.tx}, 32'd1);
    chk("busy low on reset", {31'd0, b0.busy}, 32'd0);
    q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no done after abort", dcount - d0, 0);
    chk("idle after abort", {30'd0, b0.tx, b0.busy}, 32'b10);
    set_in(v[3]);
    push_vec(v[3]);
    pulse_req();
    t0 = cyc;
    wait_done("post-reset done timeout", NB * 40 + 20);
    chk("post-reset latency", cyc - t0, NB * 40);
    repeat (50) @(negedge clk);
    chk("queue drained after reset", q.size(), 0);
    // full-rate instance: every tx edge on a 104-cycle boundary
    e_on = 1'b1;
    b1.req = 1'b1;
    @(negedge clk);
    b1.req = 1'b0;
    i = 0;
    while (!b1.done && i < NB * 1040 + 50) begin
      @(negedge clk);
      i++;
    end
    chk("104 done timeout", {31'd0, b1.done}, 32'd1);
    chk("104 start seen", {31'd0, seen}, 32'd1);
    chk("104 packet latency", cyc - t1, NB * 1040);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
